// File: rtl/easy_fifo_sync_flags.sv
// easy_fifo_sync_flags: single-clock FIFO with occupancy counter, almost-full/
// almost-empty flags, sticky overflow/underflow errors and a selectable read
// mode (registered read or first-word-fall-through).
//
// Handshake: a write is taken on a rising edge when wr_en is high and wr_full
// is low; a read is taken when rd_en is high and rd_empty is low. Both gates
// look only at the flags of the current cycle, so a simultaneous read never
// makes room for a write into a full FIFO, and a simultaneous write never
// satisfies a read from an empty one. In registered mode rd_valid pulses for
// one cycle, one cycle after the accepted read; in FWFT mode rd_valid simply
// means "rd_data is the head entry" and rd_en acknowledges it.
module easy_fifo_sync_flags #(
    parameter int DWIDTH    = 32,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DWIDTH-1:0]          wr_data,
    input  logic                       wr_en,
    output logic                       wr_full,
    output logic                       wr_afull,
    output logic                       wr_overflow,
    input  logic                       rd_en,
    output logic [DWIDTH-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       rd_empty,
    output logic                       rd_aempty,
    output logic                       rd_underflow,
    input  logic                       clr_err,
    output logic [$clog2(DEPTH):0]     fifo_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              wr_acc;
    logic              rd_acc;

    // Flags are decoded from the registered count, so they move the cycle after the edge.
    assign wr_full   = (cnt_q == FULL_C);
    assign rd_empty  = (cnt_q == '0);
    assign wr_afull  = (cnt_q >= AFULL_C);
    assign rd_aempty = (cnt_q <= AEMPTY_C);
    assign fifo_cnt  = cnt_q;
    assign wr_overflow  = ovf_q;
    assign rd_underflow = udf_q;

    assign wr_acc = wr_en && !wr_full;
    assign rd_acc = rd_en && !rd_empty;

    // Next-state for pointers, occupancy and sticky errors (a new error beats clr_err).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        ovf_d = (wr_en && wr_full) || (ovf_q && !clr_err);
        udf_d = (rd_en && rd_empty) || (udf_q && !clr_err);
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array; contents survive reset and are simply abandoned by the pointer reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head entry is shown directly; stale head is driven while empty.
            assign rd_data  = mem_q[rd_ptr_q];
            assign rd_valid = !rd_empty;
        end else begin : g_std
            logic [DWIDTH-1:0] rd_data_q, rd_data_d;
            logic              rd_valid_q, rd_valid_d;

            // Output register loads only on an accepted read and holds otherwise.
            always_comb begin
                rd_data_d  = rd_data_q;
                rd_valid_d = rd_acc;
                if (rd_acc) rd_data_d = mem_q[rd_ptr_q];
            end

            // Registered read data and its one-cycle valid pulse.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_data_q  <= rd_data_d;
                    rd_valid_q <= rd_valid_d;
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_easy_fifo_sync_flags.sv
// Bench for easy_fifo_sync_flags: a registered-read instance checked through a
// reference queue and an expected-read-data scoreboard, plus a FWFT instance
// checked with directed values.
module tb_easy_fifo_sync_flags;

    localparam int DW  = 32;
    localparam int DEP = 16;
    localparam int CW  = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // registered-read instance
    logic [DW-1:0] wr_data, rd_data;
    logic          wr_en, rd_en, clr_err;
    logic          wr_full, wr_afull, wr_overflow;
    logic          rd_valid, rd_empty, rd_aempty, rd_underflow;
    logic [CW-1:0] fifo_cnt;

    // FWFT instance
    logic [DW-1:0] f_wr_data, f_rd_data;
    logic          f_wr_en, f_rd_en, f_clr_err;
    logic          f_wr_full, f_wr_afull, f_wr_overflow;
    logic          f_rd_valid, f_rd_empty, f_rd_aempty, f_rd_underflow;
    logic [CW-1:0] f_fifo_cnt;

    easy_fifo_sync_flags #(.DWIDTH(DW), .DEPTH(DEP), .FWFT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_data(wr_data), .wr_en(wr_en),
        .wr_full(wr_full), .wr_afull(wr_afull), .wr_overflow(wr_overflow),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_empty(rd_empty), .rd_aempty(rd_aempty), .rd_underflow(rd_underflow),
        .clr_err(clr_err), .fifo_cnt(fifo_cnt)
    );

    easy_fifo_sync_flags #(.DWIDTH(DW), .DEPTH(DEP), .FWFT(1)) dut_fwft (
        .clk(clk), .rst_n(rst_n),
        .wr_data(f_wr_data), .wr_en(f_wr_en),
        .wr_full(f_wr_full), .wr_afull(f_wr_afull), .wr_overflow(f_wr_overflow),
        .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
        .rd_empty(f_rd_empty), .rd_aempty(f_rd_aempty), .rd_underflow(f_rd_underflow),
        .clr_err(f_clr_err), .fifo_cnt(f_fifo_cnt)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_q[$];
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_state();
        int n;
        n = model_q.size();
        check("fifo_cnt",     32'(fifo_cnt),  32'(n));
        check("wr_full",      32'(wr_full),   32'(n == DEP));
        check("rd_empty",     32'(rd_empty),  32'(n == 0));
        check("wr_afull",     32'(wr_afull),  32'(n >= DEP - 2));
        check("rd_aempty",    32'(rd_aempty), 32'(n <= 2));
        check("wr_overflow",  32'(wr_overflow),  32'(m_ovf));
        check("rd_underflow", 32'(rd_underflow), 32'(m_udf));
    endtask

    // Monitor: every rd_valid pulse must match the next expected read word.
    task automatic monitor_loop();
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("rd_valid_unexpected", 32'(rd_valid), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", rd_data, e);
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic do_op(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        logic full, empty, wa, ra;
        wr_en = w; wr_data = d; rd_en = r; clr_err = c;
        full  = (model_q.size() == DEP);
        empty = (model_q.size() == 0);
        wa = w && !full;
        ra = r && !empty;
        @(posedge clk);
        if (ra) exp_q.push_back(model_q.pop_front());
        if (wa) model_q.push_back(d);
        m_ovf = (w && full)  || (m_ovf && !c);
        m_udf = (r && empty) || (m_udf && !c);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        check_state();
    endtask

    task automatic f_step(input logic w, input logic [DW-1:0] d, input logic r);
        f_wr_en = w; f_wr_data = d; f_rd_en = r;
        @(posedge clk);
        #1;
        f_wr_en = 1'b0; f_rd_en = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cnt"},    32'(fifo_cnt),     32'(0));
        check({tag, "_empty"},  32'(rd_empty),     32'(1));
        check({tag, "_aempty"}, 32'(rd_aempty),    32'(1));
        check({tag, "_full"},   32'(wr_full),      32'(0));
        check({tag, "_afull"},  32'(wr_afull),     32'(0));
        check({tag, "_valid"},  32'(rd_valid),     32'(0));
        check({tag, "_data"},   rd_data,           32'(0));
        check({tag, "_ovf"},    32'(wr_overflow),  32'(0));
        check({tag, "_udf"},    32'(rd_underflow), 32'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
        f_wr_en = 1'b0; f_rd_en = 1'b0; f_clr_err = 1'b0; f_wr_data = '0;
        fork
            monitor_loop();
        join_none

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        #2 rst_n = 1'b1;

        // Fill 0..15; afull appears from count 14, full at 16.
        for (int i = 0; i < DEP; i++) do_op(1'b1, DW'(i), 1'b0, 1'b0);
        // 17th write overflows, count holds.
        do_op(1'b1, 32'd16, 1'b0, 1'b0);
        check("ovf_17th_write", 32'(wr_overflow), 32'(1));
        check("cnt_after_ovf",  32'(fifo_cnt),    32'(16));

        // Drain all 16 in order, then one read too many.
        for (int i = 0; i < DEP; i++) do_op(1'b0, '0, 1'b1, 1'b0);
        do_op(1'b0, '0, 1'b1, 1'b0);
        check("udf_extra_read", 32'(rd_underflow), 32'(1));
        do_op(1'b0, '0, 1'b0, 1'b1);

        // Count 3 then 40 cycles of simultaneous write+read across the wrap.
        for (int i = 0; i < 3; i++) do_op(1'b1, DW'(100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) do_op(1'b1, DW'(200 + i), 1'b1, 1'b0);
        check("cnt_steady_3", 32'(fifo_cnt), 32'(3));
        while (model_q.size() > 0) do_op(1'b0, '0, 1'b1, 1'b0);

        // Full: read taken, write rejected.
        for (int i = 0; i < DEP; i++) do_op(1'b1, DW'(300 + i), 1'b0, 1'b0);
        do_op(1'b1, 32'd999, 1'b1, 1'b0);
        check("full_rw_cnt", 32'(fifo_cnt),    32'(15));
        check("full_rw_ovf", 32'(wr_overflow), 32'(1));
        do_op(1'b0, '0, 1'b0, 1'b1);
        while (model_q.size() > 0) do_op(1'b0, '0, 1'b1, 1'b0);

        // Empty: write taken, read rejected.
        do_op(1'b1, 32'h55, 1'b1, 1'b0);
        check("empty_rw_cnt", 32'(fifo_cnt),     32'(1));
        check("empty_rw_udf", 32'(rd_underflow), 32'(1));
        do_op(1'b0, '0, 1'b0, 1'b1);

        // clr_err in the same cycle as a new overflow keeps the flag set.
        while (model_q.size() < DEP) do_op(1'b1, DW'(400 + model_q.size()), 1'b0, 1'b0);
        do_op(1'b1, 32'd777, 1'b0, 1'b1);
        check("ovf_beats_clr", 32'(wr_overflow), 32'(1));

        // Drain, refill 8, then reset in the middle of a cycle.
        while (model_q.size() > 0) do_op(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) do_op(1'b1, DW'(500 + i), 1'b0, 1'b0);
        do_op(1'b0, '0, 1'b0, 1'b0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        #3 rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        model_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        #2 rst_n = 1'b1;
        do_op(1'b0, '0, 1'b0, 1'b0);
        do_op(1'b1, 32'h1234, 1'b0, 1'b0);
        do_op(1'b0, '0, 1'b1, 1'b0);
        do_op(1'b0, '0, 1'b0, 1'b0);

        // FWFT instance: head appears without rd_en, rd_en pops it.
        check("fwft_reset_valid", 32'(f_rd_valid), 32'(0));
        check("fwft_reset_empty", 32'(f_rd_empty), 32'(1));
        f_step(1'b1, 32'hA5A5A5A5, 1'b0);
        check("fwft_valid",  32'(f_rd_valid), 32'(1));
        check("fwft_data",   f_rd_data,       32'hA5A5A5A5);
        check("fwft_cnt1",   32'(f_fifo_cnt), 32'(1));
        f_step(1'b0, '0, 1'b1);
        check("fwft_empty_after_pop", 32'(f_rd_empty), 32'(1));
        check("fwft_valid_after_pop", 32'(f_rd_valid), 32'(0));
        f_step(1'b1, 32'h11, 1'b0);
        f_step(1'b1, 32'h22, 1'b0);
        check("fwft_head_11", f_rd_data, 32'h11);
        f_step(1'b0, '0, 1'b1);
        check("fwft_head_22", f_rd_data,        32'h22);
        check("fwft_valid_22", 32'(f_rd_valid), 32'(1));
        f_step(1'b0, '0, 1'b1);
        check("fwft_empty_end", 32'(f_rd_empty), 32'(1));
        f_step(1'b0, '0, 1'b1);
        check("fwft_udf", 32'(f_rd_underflow), 32'(1));

        check("scoreboard_leftover", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
